// File: rtl/tx_ctrl_q.sv
// Queued UART transmit controller: word FIFO, sticky connect request with priority,
// optional idle heartbeat and a built-in start/data/stop serializer.
module tx_ctrl_q #(
  parameter int         CLK_PER_BIT = 434,
  parameter int         DATA_W      = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [8:0] CONN_BYTE   = 9'h0FF,
  parameter logic [8:0] HB_BYTE     = 9'h000,
  parameter int         HB_CYC      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_ctrl_conn,
  input  logic                          i_lost,
  input  logic                          i_send,
  input  logic [DATA_W-1:0]             i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [1:0]                    o_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CYC_W  = $clog2(CLK_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W + 2);
  localparam int HB_W   = $clog2(HB_CYC + 2);
  localparam bit HB_EN  = (HB_CYC != 0);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W + 1);
  localparam logic [HB_W-1:0]   HB_LAST  = HB_W'((HB_CYC > 0) ? HB_CYC - 1 : 0);
  localparam logic [DATA_W-1:0] CONN_WORD = CONN_BYTE[DATA_W-1:0];
  localparam logic [DATA_W-1:0] HB_WORD   = HB_BYTE[DATA_W-1:0];

  typedef enum logic [1:0] {LOST = 2'd0, IDLE = 2'd1, LOAD = 2'd2, BUSY = 2'd3} state_t;
  typedef enum logic [1:0] {SRC_FIFO = 2'd0, SRC_CONN = 2'd1, SRC_HB = 2'd2} src_t;

  state_t             state;
  state_t             state_next;
  src_t               src;
  logic               conn_latch;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  load_word;
  logic [DATA_W:0]    shreg;
  logic [CYC_W-1:0]   bit_cyc;
  logic [IDX_W-1:0]   bit_idx;
  logic [HB_W-1:0]    hb_cnt;
  logic               tx;
  logic               overflow;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic sel_conn;
  logic sel_hb;
  logic idle_free;
  logic hb_due;
  logic frame_done;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push       = i_send && !fifo_full && !i_lost;
  assign sel_conn   = conn_latch && ((state == LOST) || (state == IDLE));
  assign idle_free  = (state == IDLE) && !conn_latch && !i_lost;
  assign pop        = idle_free && !fifo_empty;
  assign hb_due     = HB_EN && (hb_cnt == HB_LAST);
  assign sel_hb     = idle_free && fifo_empty && hb_due;
  assign frame_done = (state == BUSY) && (bit_cyc == CYC_LAST) && (bit_idx == IDX_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOST;
    else        state <= state_next;
  end

  // Next-state logic; connect request outranks link loss in both LOST and IDLE
  always_comb begin
    state_next = state;
    case (state)
      LOST: begin
        if (conn_latch)   state_next = LOAD;
        else if (!i_lost) state_next = IDLE;
      end
      IDLE: begin
        if (sel_conn)            state_next = LOAD;
        else if (i_lost)         state_next = LOST;
        else if (pop || sel_hb)  state_next = LOAD;
      end
      LOAD:    state_next = BUSY;
      BUSY:    if (frame_done) state_next = IDLE;
      default: state_next = LOST;
    endcase
  end

  // Outputs
  always_comb begin
    o_state      = state;
    o_busy       = (state == LOAD) || (state == BUSY);
    o_ready      = !fifo_full && !i_lost;
    o_fifo_count = count;
    o_tx         = tx;
    o_overflow   = overflow;
  end

  // FIFO pointers and occupancy; link loss flushes the queue every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= i_send && !i_lost && fifo_full;
      if (i_lost) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Storage array with registered read; the head captured at the pop edge feeds LOAD
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conn_latch <= 1'b0;
      src        <= SRC_FIFO;
      hb_cnt     <= '0;
    end else begin
      conn_latch <= i_ctrl_conn || (conn_latch && !sel_conn);
      if (sel_conn)    src <= SRC_CONN;
      else if (pop)    src <= SRC_FIFO;
      else if (sel_hb) src <= SRC_HB;
      if ((state == IDLE) && (state_next == IDLE) && fifo_empty && !conn_latch)
        hb_cnt <= hb_cnt + 1'b1;
      else
        hb_cnt <= '0;
    end
  end

  always_comb begin
    case (src)
      SRC_CONN: load_word = CONN_WORD;
      SRC_HB:   load_word = HB_WORD;
      default:  load_word = rd_data;
    endcase
  end

  // Serializer: bit_idx 0 = start, 1..DATA_W = data, DATA_W+1 = stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      shreg   <= '1;
      bit_cyc <= '0;
      bit_idx <= '0;
    end else if (state == LOAD) begin
      tx      <= 1'b0;
      shreg   <= {1'b1, load_word};
      bit_cyc <= '0;
      bit_idx <= '0;
    end else if (state == BUSY) begin
      if (bit_cyc == CYC_LAST) begin
        bit_cyc <= '0;
        if (bit_idx != IDX_LAST) begin
          bit_idx <= bit_idx + 1'b1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[DATA_W:1]};
        end
      end else begin
        bit_cyc <= bit_cyc + 1'b1;
      end
    end else begin
      tx <= 1'b1;
    end
  end

endmodule

// File: doc/tx_ctrl_q.md
# tx_ctrl_q

Queued, parametrised UART transmit controller. Successor to the single-byte TX control block. Adds:
- a FIFO of outgoing data words;
- a prioritised connect byte;
- an optional idle heartbeat;
- a built-in serializer with defined reset.

Sits between the keypad/command logic and the board UART TX pin.

## Interface
- CLK_PER_BIT, 434: clock cycles per UART bit (>=2).
- DATA_W, 8: data bits per frame (5..9).
- FIFO_DEPTH, 4: queue entries; power of two, >=2.
- CONN_BYTE, 8'hFF: word sent on a connect request (low DATA_W bits used).
- HB_BYTE, 8'h00: heartbeat word.
- HB_CYC, 0: idle cycles before a heartbeat; 0 disables heartbeat.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_ctrl_conn  in  1  connect request pulse; latched (sticky) until served.
- i_lost  in  1  link-lost level.
- i_send  in  1  push request; accepted when i_send && o_ready.
- i_data  in  DATA_W  word to queue.
- o_ready  out  1  = !fifo_full && !i_lost.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high in LOAD or BUSY.
- o_state  out  2  FSM state: LOST=0, IDLE=1, LOAD=2, BUSY=3.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries.
- o_overflow  out  1  one-cycle pulse when a push is dropped because the FIFO is full.

## Operation
- Reset values: state LOST, FIFO empty (count 0), conn latch 0, heartbeat counter 0, o_tx=1, o_busy=0, o_overflow=0. o_ready follows its equation.
- Frame format: start bit 0, DATA_W data bits LSB first, stop bit 1. Each bit lasts exactly CLK_PER_BIT cycles.
- Conn latch: set by i_ctrl_conn in any state. Cleared when the connect word is selected.
- FIFO: circular buffer with wrapping pointers. Push and pop in the same cycle are legal and leave the count unchanged. A push while full is dropped, pulses o_overflow, and leaves contents unchanged.
- While i_lost=1: FIFO is cleared synchronously every cycle and pushes are ignored (o_ready=0). Dropped pushes here do not pulse o_overflow.
- FSM:
  - LOST:
    - conn latch set → select CONN_BYTE, go to LOAD (takes priority over i_lost);
    - else i_lost=1 → stay in LOST;
    - else → IDLE.
  - IDLE, in priority order:
    - conn latch → CONN_BYTE;
    - i_lost → LOST;
    - FIFO non-empty → pop head, go to LOAD;
    - heartbeat due → HB_BYTE, go to LOAD.
  - LOAD: load shift register, drive start bit, go to BUSY.
  - BUSY: shift bits out. At the end of the stop bit → IDLE. An i_lost during a frame never truncates it.
- Heartbeat counter:
  - increments in IDLE when FIFO is empty and conn latch is clear;
  - resets to 0 on any exit from IDLE and whenever the FIFO is non-empty;
  - heartbeat is due when the counter reaches HB_CYC-1. Never due when HB_CYC=0.

## Timing
- A push accepted at edge E0 in IDLE with an empty FIFO:
  - pop at E0+1 (state LOAD);
  - o_tx falls at E0+2 (state BUSY).
- o_tx falls at the LOAD→BUSY edge. The state returns to IDLE exactly (DATA_W+2)*CLK_PER_BIT cycles later; o_tx stays 1 across that edge.
- Back-to-back frames: the FIFO is popped at the IDLE cycle immediately following BUSY. The gap between a stop-bit end and the next start bit is 2 cycles.
- A conn request arriving mid-frame is sent directly after the current frame, ahead of any queued words.
- o_ready and o_fifo_count update on the edge after a push or pop.
- Asserting rst_n low mid-frame forces o_tx=1 and the reset state immediately, without waiting for a clock edge.

## Test plan
- **Reset and basic frame.** Release rst_n with i_lost=0; push 8'hA5 at CLK_PER_BIT=4.
  - State goes LOST→IDLE.
  - o_tx carries bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles long.
  - o_busy stays high for exactly 40 cycles plus the LOAD cycle.
- **Queue ordering and overflow.** With FIFO_DEPTH=4, push 5 words back-to-back while the serializer is busy.
  - o_ready drops at count 4.
  - The 5th push pulses o_overflow for one cycle.
  - The 4 accepted words are sent in order with 2-cycle gaps.
- **Connect priority.** Pulse i_ctrl_conn mid-frame while 2 words are queued.
  - 8'hFF is sent next, followed by the 2 queued words.
  - Pulse i_ctrl_conn in LOST with i_lost=1: 8'hFF is sent, then the state returns to LOST.
- **Link loss.** Assert i_lost mid-frame with 3 words queued.
  - The current frame completes.
  - o_fifo_count reads 0 the next cycle.
  - State goes to LOST; pushes are ignored and o_overflow stays 0.
- **Heartbeat.** With HB_CYC=20 and nothing queued, 8'h00 starts 20 cycles after entering IDLE.
  - A push before cycle 20 restarts the count.
  - With HB_CYC=0, no frame is ever sent.
- **Async reset mid-frame.** Drop rst_n mid-frame between clock edges.
  - o_tx goes to 1 immediately.
  - State reads LOST and FIFO count 0 with no clock edge.
